memory_arbiter_rr: RTL and testbench

MEMORY_ARBITER_RR -- requirements
Module: memory_arbiter_rr

---
 rtl/memory_arbiter_rr.sv | 162 ++++++++++++++++
 tb/tb_memory_arbiter_rr.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter sharing one memory port between CPUS cores, each with a data
// and an instruction requester. Data requests always win; a grant is held until done.
module memory_arbiter_rr #(
   parameter int CPUS = 2,
   parameter int AW   = 32,
   parameter int DW   = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CPUS-1:0]           iREN,
   input  logic [CPUS-1:0]           dREN,
   input  logic [CPUS-1:0]           dWEN,
   input  logic [CPUS*AW-1:0]        iaddr,
   input  logic [CPUS*AW-1:0]        daddr,
   input  logic [CPUS*DW-1:0]        dstore,
   output logic [CPUS-1:0]           iwait,
   output logic [CPUS-1:0]           dwait,
   output logic [CPUS*DW-1:0]        iload,
   output logic [CPUS*DW-1:0]        dload,
   output logic                      ramREN,
   output logic                      ramWEN,
   output logic [AW-1:0]             ramaddr,
   output logic [DW-1:0]             ramstore,
   input  logic [DW-1:0]             ramload,
   input  logic [1:0]                ramstate,
   output logic                      ramerr,
   output logic [$clog2(2*CPUS):0]   grant_id
);

   localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int GW = $clog2(2*CPUS) + 1;

   typedef enum logic {IDLE, OWN} state_t;
   typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

   state_t          state, state_n;
   logic [PW-1:0]   owner, owner_n;
   logic            owner_instr, owner_instr_n;
   logic [PW-1:0]   dptr, dptr_n;
   logic [PW-1:0]   iptr, iptr_n;
   logic [CPUS-1:0] dreq;
   logic            own_req;

   // First requester at or above ptr, wrapping modulo CPUS.
   function automatic logic [PW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                             input logic [PW-1:0]   ptr);
      logic [PW-1:0] pick;
      logic [PW:0]   sum;
      logic          found;
      pick  = ptr;
      found = 1'b0;
      for (int off = 0; off < CPUS; off++) begin
         sum = {1'b0, ptr} + (PW+1)'(off);
         if (sum >= (PW+1)'(CPUS))
            sum = sum - (PW+1)'(CPUS);
         if (!found && req[sum[PW-1:0]]) begin
            pick  = sum[PW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
      return (g == PW'(CPUS-1)) ? '0 : g + 1'b1;
   endfunction

   assign dreq  = dREN | dWEN;
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

   always_comb begin
      // NOTE: every output and next-state value gets a default first, so no path
      // through the case below can leave one unassigned and infer a latch.
      state_n       = state;
      owner_n       = owner;
      owner_instr_n = owner_instr;
      dptr_n        = dptr;
      iptr_n        = iptr;
      own_req       = 1'b0;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      ramerr        = 1'b0;
      iwait         = '1;
      dwait         = '1;
      grant_id      = '0;

      case (state)
         IDLE: begin
            if (|dreq) begin
               state_n       = OWN;
               owner_n       = rr_pick(dreq, dptr);
               owner_instr_n = 1'b0;
            end else if (|iREN) begin
               state_n       = OWN;
               owner_n       = rr_pick(iREN, iptr);
               owner_instr_n = 1'b1;
            end
         end

         OWN: begin
            grant_id = owner_instr ? GW'(CPUS) + GW'(owner) : GW'(owner);
            own_req  = owner_instr ? iREN[owner] : dreq[owner];

            // A withdrawn request releases the memory immediately, without credit.
            if (!own_req) begin
               state_n = IDLE;
            end else begin
               if (owner_instr) begin
                  ramREN  = 1'b1;
                  ramaddr = iaddr[owner*AW +: AW];
               end else begin
                  ramWEN   = dWEN[owner];
                  ramREN   = !dWEN[owner];
                  ramaddr  = daddr[owner*AW +: AW];
                  ramstore = dstore[owner*DW +: DW];
               end

               case (ramstate)
                  RAM_ACCESS: begin
                     state_n = IDLE;
                     if (owner_instr) begin
                        iwait[owner] = 1'b0;
                        iptr_n       = next_ptr(owner);
                     end else begin
                        dwait[owner] = 1'b0;
                        dptr_n       = next_ptr(owner);
                     end
                  end
                  RAM_ERROR: begin
                     ramerr  = 1'b1;
                     state_n = IDLE;
                  end
                  default: ;
               endcase
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (RST) begin
         state       <= IDLE;
         owner       <= '0;
         owner_instr <= 1'b0;
         dptr        <= '0;
         iptr        <= '0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         owner_instr <= owner_instr_n;
         dptr        <= dptr_n;
         iptr        <= iptr_n;
      end
   end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Bench for memory_arbiter_rr: CPUS=2 instance checked cycle by cycle against a
// transaction-level reference model, plus a CPUS=4 instance for instruction rotation.
module tb_memory_arbiter_rr;

   localparam int N   = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int GW  = $clog2(2*N) + 1;
   localparam int N4  = 4;
   localparam int GW4 = $clog2(2*N4) + 1;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST;

   logic [N-1:0]    iren, dren, dwen;
   logic [N*AW-1:0] iaddr, daddr;
   logic [N*DW-1:0] dstore;
   logic [N-1:0]    iwait, dwait;
   logic [N*DW-1:0] iload, dload;
   logic            ram_ren, ram_wen, ramerr;
   logic [AW-1:0]   ramaddr;
   logic [DW-1:0]   ramstore, ramload;
   logic [1:0]      ramstate;
   logic [GW-1:0]   grant_id;

   logic [N4-1:0]    iren_b, dren_b, dwen_b;
   logic [N4*AW-1:0] iaddr_b, daddr_b;
   logic [N4*DW-1:0] dstore_b;
   logic [N4-1:0]    iwait_b, dwait_b;
   logic [N4*DW-1:0] iload_b, dload_b;
   logic             ram_ren_b, ram_wen_b, ramerr_b;
   logic [AW-1:0]    ramaddr_b;
   logic [DW-1:0]    ramstore_b, ramload_b;
   logic [1:0]       ramstate_b;
   logic [GW4-1:0]   grant_id_b;

   memory_arbiter_rr #(.CPUS(N), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iren), .dREN(dren), .dWEN(dwen),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr), .grant_id(grant_id)
   );

   memory_arbiter_rr #(.CPUS(N4), .AW(AW), .DW(DW)) dut_b (
      .CLK(CLK), .RST(RST),
      .iREN(iren_b), .dREN(dren_b), .dWEN(dwen_b),
      .iaddr(iaddr_b), .daddr(daddr_b), .dstore(dstore_b),
      .iwait(iwait_b), .dwait(dwait_b), .iload(iload_b), .dload(dload_b),
      .ramREN(ram_ren_b), .ramWEN(ram_wen_b), .ramaddr(ramaddr_b), .ramstore(ramstore_b),
      .ramload(ramload_b), .ramstate(ramstate_b), .ramerr(ramerr_b), .grant_id(grant_id_b)
   );

   typedef struct packed {
      logic          ren;
      logic          wen;
      logic          err;
      logic [GW-1:0] gid;
      logic [N-1:0]  iw;
      logic [N-1:0]  dw;
      logic [AW-1:0] addr;
      logic [DW-1:0] store;
   } obs_t;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: who holds the memory (if anyone) and the two rotation pointers.
   bit m_busy;
   bit m_instr;
   int m_core;
   int m_dptr;
   int m_iptr;

   function automatic obs_t dut_obs();
      return '{ram_ren, ram_wen, ramerr, grant_id, iwait, dwait, ramaddr, ramstore};
   endfunction

   function automatic bit m_live();
      if (m_instr)
         return iren[m_core +: 1] == 1'b1;
      return (dren[m_core +: 1] | dwen[m_core +: 1]) == 1'b1;
   endfunction

   function automatic obs_t model_obs();
      obs_t e;
      e    = '0;
      e.iw = '1;
      e.dw = '1;
      if (m_busy) begin
         e.gid = GW'(m_instr ? N + m_core : m_core);
         if (m_live()) begin
            if (m_instr) begin
               e.ren  = 1'b1;
               e.addr = iaddr[m_core*AW +: AW];
            end else begin
               e.wen   = dwen[m_core +: 1];
               e.ren   = !dwen[m_core +: 1];
               e.addr  = daddr[m_core*AW +: AW];
               e.store = dstore[m_core*DW +: DW];
            end
            if (ramstate == 2'd2) begin
               if (m_instr) e.iw[m_core +: 1] = 1'b0;
               else         e.dw[m_core +: 1] = 1'b0;
            end
            if (ramstate == 2'd3) e.err = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic model_edge();
      bit found;
      int c;
      found = 1'b0;
      if (RST) begin
         m_busy = 1'b0; m_instr = 1'b0; m_core = 0; m_dptr = 0; m_iptr = 0;
      end else if (!m_busy) begin
         if ((dren | dwen) != '0) begin
            for (int j = 0; j < N; j++) begin
               c = (m_dptr + j) % N;
               if (!found && (dren[c +: 1] | dwen[c +: 1]) == 1'b1) begin
                  m_core = c;
                  found  = 1'b1;
               end
            end
            m_busy = 1'b1; m_instr = 1'b0;
         end else if (iren != '0) begin
            for (int j = 0; j < N; j++) begin
               c = (m_iptr + j) % N;
               if (!found && iren[c +: 1] == 1'b1) begin
                  m_core = c;
                  found  = 1'b1;
               end
            end
            m_busy = 1'b1; m_instr = 1'b1;
         end
      end else begin
         if (!m_live() || ramstate == 2'd3) begin
            m_busy = 1'b0;
         end else if (ramstate == 2'd2) begin
            m_busy = 1'b0;
            if (m_instr) m_iptr = (m_core + 1) % N;
            else         m_dptr = (m_core + 1) % N;
         end
      end
   endtask

   // One rising edge; the model advances with the DUT, inputs change 1 ns later.
   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      iren = '0; dren = '0; dwen = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = 2'd0;
      iren_b = '0; dren_b = '0; dwen_b = '0;
      iaddr_b = '0; daddr_b = '0; dstore_b = '0;
      ramload_b = '0; ramstate_b = 2'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic randomize_data();
      iaddr  = {$urandom, $urandom};
      daddr  = {$urandom, $urandom};
      dstore = {$urandom, $urandom};
   endtask

   task automatic test_reset();
      obs_t got, idle_obs;
      idle_obs    = '0;
      idle_obs.iw = '1;
      idle_obs.dw = '1;
      clear_inputs();
      RST = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         // Requests while reset is held must not produce a grant.
         iren = '1; dren = '1; ramstate = 2'd2;
         ramload = $urandom;
         #4;
         got = dut_obs();
         tests_run++;
         if (got !== idle_obs) begin
            tests_failed++;
            $display("FAIL reset_idle cycle %0d: dut %h, required %h", c, got, idle_obs);
         end
         tests_run++;
         if (iload !== {N{ramload}} || dload !== {N{ramload}}) begin
            tests_failed++;
            $display("FAIL load_broadcast cycle %0d: iload %h dload %h, ramload %h",
                     c, iload, dload, ramload);
         end
         tick();
      end
      RST = 1'b0;
      clear_inputs();
   endtask

   task automatic test_data_priority();
      obs_t got, exp;
      do_reset();
      randomize_data();
      iren = 2'b01; dren = 2'b10; ramstate = 2'd2;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) dren = '0;
         if (c == 4) iren = '0;
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL priority cycle %0d: dut %h, model %h", c, got, exp);
         end
         if (c == 1) begin
            tests_run++;
            if (dwait !== 2'b01 || iwait !== 2'b11) begin
               tests_failed++;
               $display("FAIL priority_data_first: dwait %b iwait %b, required 01 11", dwait, iwait);
            end
         end
         if (c == 3) begin
            tests_run++;
            if (iwait !== 2'b10) begin
               tests_failed++;
               $display("FAIL priority_instr_after: iwait %b, required 10", iwait);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      obs_t got, exp;
      int   gids[$];
      logic [AW-1:0] addrs[$];
      logic [DW-1:0] stores[$];
      do_reset();
      randomize_data();
      dwen = 2'b11; ramstate = 2'd2;
      for (int c = 0; c < 8; c++) begin
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL back_to_back cycle %0d: dut %h, model %h", c, got, exp);
         end
         if (ram_wen === 1'b1) begin
            gids.push_back(int'(grant_id));
            addrs.push_back(ramaddr);
            stores.push_back(ramstore);
         end
         tick();
      end
      tests_run++;
      if (gids.size() != 4) begin
         tests_failed++;
         $display("FAIL b2b_count: %0d write grants, required 4", gids.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (gids[i] != i % 2 || addrs[i] !== daddr[(i%2)*AW +: AW] ||
                stores[i] !== dstore[(i%2)*DW +: DW]) begin
               tests_failed++;
               $display("FAIL b2b_grant %0d: id %0d addr %h data %h, required id %0d addr %h data %h",
                        i, gids[i], addrs[i], stores[i], i % 2,
                        daddr[(i%2)*AW +: AW], dstore[(i%2)*DW +: DW]);
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_busy_wait();
      obs_t got, exp;
      do_reset();
      randomize_data();
      dren = 2'b01;
      for (int c = 0; c < 6; c++) begin
         ramstate = (c >= 4) ? 2'd2 : 2'd1;
         if (c == 5) dren = '0;
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL busy_wait cycle %0d: dut %h, model %h", c, got, exp);
         end
         if (c >= 1 && c <= 4) begin
            tests_run++;
            if (dwait[0] !== (c != 4) || ramaddr !== daddr[AW-1:0] || ram_ren !== 1'b1) begin
               tests_failed++;
               $display("FAIL busy_hold cycle %0d: dwait0 %b addr %h ren %b, required %b %h 1",
                        c, dwait[0], ramaddr, ram_ren, c != 4, daddr[AW-1:0]);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_error();
      obs_t got, exp;
      do_reset();
      randomize_data();
      dren = 2'b10;
      for (int c = 0; c < 5; c++) begin
         ramstate = (c == 1) ? 2'd3 : (c == 3) ? 2'd2 : 2'd1;
         if (c == 4) dren = '0;
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL error cycle %0d: dut %h, model %h", c, got, exp);
         end
         if (c == 1) begin
            tests_run++;
            if (ramerr !== 1'b1 || dwait !== 2'b11) begin
               tests_failed++;
               $display("FAIL error_pulse: ramerr %b dwait %b, required 1 11", ramerr, dwait);
            end
         end
         if (c == 2) begin
            tests_run++;
            if (ramerr !== 1'b0) begin
               tests_failed++;
               $display("FAIL error_one_cycle: ramerr %b, required 0", ramerr);
            end
         end
         if (c == 3) begin
            tests_run++;
            if (grant_id !== GW'(1) || dwait !== 2'b01) begin
               tests_failed++;
               $display("FAIL error_regrant: grant %0d dwait %b, required 1 01", grant_id, dwait);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_own();
      obs_t got, exp;
      do_reset();
      randomize_data();
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin dren = 2'b01; ramstate = 2'd2; end
            2: begin dren = 2'b11; ramstate = 2'd1; end
            3: RST = 1'b1;
            4: RST = 1'b0;
            default: ;
         endcase
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid_own cycle %0d: dut %h, model %h", c, got, exp);
         end
         if (c == 4) begin
            tests_run++;
            if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || iwait !== 2'b11 || dwait !== 2'b11) begin
               tests_failed++;
               $display("FAIL reset_release: ren %b wen %b iwait %b dwait %b, required 0 0 11 11",
                        ram_ren, ram_wen, iwait, dwait);
            end
         end
         if (c == 5) begin
            tests_run++;
            if (grant_id !== GW'(0) || ram_ren !== 1'b1) begin
               tests_failed++;
               $display("FAIL reset_ptr_cleared: grant %0d ren %b, required 0 1", grant_id, ram_ren);
            end
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_random();
      obs_t got, exp;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         randomize_data();
         iren     = N'($urandom_range(0, 3));
         dren     = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : '0;
         dwen     = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : '0;
         ramstate = 2'($urandom_range(0, 3));
         ramload  = $urandom;
         RST      = ($urandom_range(0, 39) == 0);
         #4;
         got = dut_obs();
         exp = model_obs();
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL random cycle %0d: dut %h, model %h", c, got, exp);
         end
         tick();
      end
      RST = 1'b0;
      clear_inputs();
   endtask

   task automatic test_cpus4_rotation();
      int gids[$];
      logic [AW-1:0] addrs[$];
      do_reset();
      iaddr_b    = {$urandom, $urandom, $urandom, $urandom};
      iren_b     = '1;
      ramstate_b = 2'd2;
      for (int c = 0; c < 20 && gids.size() < 5; c++) begin
         #4;
         if (ram_ren_b === 1'b1) begin
            gids.push_back(int'(grant_id_b));
            addrs.push_back(ramaddr_b);
         end
         tick();
      end
      tests_run++;
      if (gids.size() != 5) begin
         tests_failed++;
         $display("FAIL cpus4_count: %0d grants within 20 cycles, required 5", gids.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (gids[i] != N4 + (i % N4) || addrs[i] !== iaddr_b[(i%N4)*AW +: AW]) begin
               tests_failed++;
               $display("FAIL cpus4_grant %0d: id %0d addr %h, required id %0d addr %h",
                        i, gids[i], addrs[i], N4 + (i % N4), iaddr_b[(i%N4)*AW +: AW]);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      clear_inputs();
      #1;
      test_reset();
      test_data_priority();
      test_back_to_back();
      test_busy_wait();
      test_error();
      test_reset_mid_own();
      test_random();
      test_cpus4_rotation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
